// File: rtl/dmem_arbiter.sv
// Two-port (core / DMA) data-memory arbiter with misalignment suppression and registered load return.
// Contention policy: fixed core priority with DMA starvation counter, or round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arbiter #(
  parameter int WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [11:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_funct3,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [11:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        MemWr,
  output logic        MemRead,
  output logic [11:0] addr,
  output logic [31:0] write_data,
  output logic [2:0]  funct3,
  input  logic [31:0] data_read,
  output logic        misalign_err
);

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [11:0] a);
    return ((f3[1:0] == 2'd1) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'b00));
  endfunction

  logic last_gnt;
  logic dma_wins;
  logic sel_we;
  logic sel_mis;
  logic any_gnt;

`ifdef DMEM_ARB_RR_EN
  // Round-robin: on contention the requester that did not win last time goes.
  always_comb begin
    dma_wins = (last_gnt == 1'b0);
  end
`else
  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  logic [CW-1:0] wait_cnt;

  always_comb begin
    dma_wins = (wait_cnt == CW'(WAIT_MAX));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wait_cnt <= '0;
    end else if (d_gnt || !d_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CW'(WAIT_MAX)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`endif

  // Grants are held off entirely while reset is asserted.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (n_rst) begin
      if (c_req && d_req) begin
        if (dma_wins) begin
          d_gnt = 1'b1;
        end else begin
          c_gnt = 1'b1;
        end
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end
  end

  always_comb begin
    MemWr      = 1'b0;
    MemRead    = 1'b0;
    addr       = '0;
    write_data = '0;
    funct3     = '0;
    sel_we     = 1'b0;
    sel_mis    = 1'b0;
    any_gnt    = c_gnt | d_gnt;
    if (c_gnt) begin
      addr       = c_addr;
      write_data = c_wdata;
      funct3     = c_funct3;
      sel_we     = c_we;
      sel_mis    = is_misaligned(c_funct3, c_addr);
    end else if (d_gnt) begin
      addr       = d_addr;
      write_data = d_wdata;
      funct3     = d_funct3;
      sel_we     = d_we;
      sel_mis    = is_misaligned(d_funct3, d_addr);
    end
    // A misaligned access still consumes its grant but never strobes memory.
    if (any_gnt) begin
      MemWr   = sel_we & ~sel_mis;
      MemRead = ~sel_we & ~sel_mis;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      c_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      misalign_err <= 1'b0;
      c_rdata      <= '0;
      d_rdata      <= '0;
      last_gnt     <= 1'b1;
    end else begin
      c_rvalid     <= c_gnt & ~c_we;
      d_rvalid     <= d_gnt & ~d_we;
      misalign_err <= any_gnt & sel_mis;
      if (c_gnt && !c_we) begin
        c_rdata <= sel_mis ? 32'h0 : data_read;
      end
      if (d_gnt && !d_we) begin
        d_rdata <= sel_mis ? 32'h0 : data_read;
      end
      if (any_gnt) begin
        last_gnt <= d_gnt;
      end else begin
        last_gnt <= last_gnt;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors push expected commands/responses, a monitor pops and compares.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        c_req, c_we, d_req, d_we;
  logic [11:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic [2:0]  c_funct3, d_funct3;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        MemWr, MemRead;
  logic [11:0] addr;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic [31:0] data_read;
  logic        misalign_err;

  always #5 clk = ~clk;

  dmem_arbiter #(.WAIT_MAX(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .MemWr(MemWr), .MemRead(MemRead), .addr(addr), .write_data(write_data), .funct3(funct3),
    .data_read(data_read), .misalign_err(misalign_err)
  );

  typedef struct packed {
    logic        req;
    logic        we;
    logic [11:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
  } req_t;

  typedef struct packed {
    logic        c;
    logic        d;
    logic        wr;
    logic        rd;
    logic [11:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
  } cmd_t;

  typedef struct packed {
    logic        crv;
    logic        drv;
    logic [31:0] rd;
    logic        mis;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   fails  = 0;
  cmd_t act_c;
  rsp_t act_r;

  // Expected contention winners (1 core, 2 DMA) for the two back-to-back contention runs.
`ifdef DMEM_ARB_RR_EN
  int win_a[6] = '{2, 1, 2, 1, 2, 1};
  int win_b[5] = '{2, 1, 2, 1, 2};
  int win_last = 2;
`else
  int win_a[6] = '{1, 1, 1, 1, 2, 1};
  int win_b[5] = '{1, 1, 1, 1, 2};
  int win_last = 1;
`endif

  function automatic req_t mk(input logic r, input logic w, input logic [11:0] a,
                              input logic [31:0] wd, input logic [2:0] f);
    return {r, w, a, wd, f};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input req_t c, input req_t d, input logic [31:0] mem);
    c_req = c.req; c_we = c.we; c_addr = c.a; c_wdata = c.wd; c_funct3 = c.f3;
    d_req = d.req; d_we = d.we; d_addr = d.a; d_wdata = d.wd; d_funct3 = d.f3;
    data_read = mem;
  endtask

  // Drives one cycle; win and mis are the hand-derived winner and misalignment for the vector.
  task automatic applyStimulus(input req_t c, input req_t d, input logic [31:0] mem,
                               input int win, input logic mis, input logic rsp_en);
    req_t w;
    drive(c, d, mem);
    if (win != 0) begin
      w = (win == 1) ? c : d;
      cmd_q.push_back({win == 1, win == 2, w.we & ~mis, ~w.we & ~mis, w.a, w.wd, w.f3});
      if (rsp_en && (!w.we || mis))
        rsp_q.push_back({(win == 1) & ~w.we, (win == 2) & ~w.we,
                         (!w.we && !mis) ? mem : 32'h0, mis});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: combinational command checked every cycle, registered responses whenever any is presented.
  always @(negedge clk) begin
    act_c = {c_gnt, d_gnt, MemWr, MemRead, addr, write_data, funct3};
    if (c_gnt || d_gnt) begin
      if (cmd_q.size() == 0) checkOutput("unexpected_grant", 64'(act_c), 64'h0);
      else checkOutput("mem_cmd", 64'(act_c), 64'(cmd_q.pop_front()));
    end else begin
      checkOutput("idle_cmd", 64'(act_c), 64'h0);
    end
    act_r = {c_rvalid, d_rvalid, (c_rvalid ? c_rdata : (d_rvalid ? d_rdata : 32'h0)), misalign_err};
    if (c_rvalid || d_rvalid || misalign_err) begin
      if (rsp_q.size() == 0) checkOutput("unexpected_rsp", 64'(act_r), 64'h0);
      else checkOutput("response", 64'(act_r), 64'(rsp_q.pop_front()));
    end
  end

  req_t idle_r;
  req_t c_ld, d_ld, c_ld2, d_st;

  initial begin
    idle_r = mk(1'b0, 1'b0, 12'h000, 32'h0, 3'd0);
    n_rst  = 1'b0;
    drive(mk(1'b1, 1'b0, 12'h010, 32'h0, 3'd2), mk(1'b1, 1'b1, 12'h040, 32'h55, 3'd2), 32'hCAFE0000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_c_rvalid", 64'(c_rvalid), 64'h0);
    checkOutput("rst_d_rvalid", 64'(d_rvalid), 64'h0);
    checkOutput("rst_misalign", 64'(misalign_err), 64'h0);
    checkOutput("rst_c_rdata", 64'(c_rdata), 64'h0);
    checkOutput("rst_d_rdata", 64'(d_rdata), 64'h0);
    checkOutput("rst_last_gnt", 64'(dut.last_gnt), 64'h1);
    n_rst = 1'b1;

    applyStimulus(mk(1'b1, 1'b0, 12'h010, 32'h0, 3'd2), idle_r, 32'hDEADBEEF, 1, 1'b0, 1'b1);
    applyStimulus(mk(1'b1, 1'b1, 12'h002, 32'h0000ABCD, 3'd1), idle_r, 32'h0, 1, 1'b0, 1'b1);
    applyStimulus(idle_r, mk(1'b1, 1'b1, 12'h006, 32'h12345678, 3'd2), 32'h0, 2, 1'b1, 1'b1);
    applyStimulus(idle_r, mk(1'b1, 1'b0, 12'h003, 32'h0, 3'd1), 32'h12345678, 2, 1'b1, 1'b1);
    applyStimulus(idle_r, mk(1'b1, 1'b0, 12'h003, 32'h0, 3'd4), 32'h000000A5, 2, 1'b0, 1'b1);
    applyStimulus(idle_r, idle_r, 32'hFFFFFFFF, 0, 1'b0, 1'b1);
    checkOutput("held_c_rdata", 64'(c_rdata), 64'hDEADBEEF);
    checkOutput("held_d_rdata", 64'(d_rdata), 64'h000000A5);
    applyStimulus(mk(1'b1, 1'b0, 12'h00E, 32'h0, 3'd5), idle_r, 32'hFFFF1234, 1, 1'b0, 1'b1);

    c_ld = mk(1'b1, 1'b0, 12'h020, 32'h0, 3'd2);
    d_ld = mk(1'b1, 1'b0, 12'h040, 32'h0, 3'd2);
    for (int i = 0; i < 6; i++)
      applyStimulus(c_ld, d_ld, 32'h10000000 + 32'(i), win_a[i], 1'b0, 1'b1);

    applyStimulus(mk(1'b1, 1'b1, 12'h100, 32'hA5A5A5A5, 3'd2), idle_r, 32'h0, 1, 1'b0, 1'b1);

    c_ld2 = mk(1'b1, 1'b0, 12'h024, 32'h0, 3'd2);
    d_st  = mk(1'b1, 1'b1, 12'h044, 32'h00000077, 3'd2);
    for (int i = 0; i < 5; i++)
      applyStimulus(c_ld2, d_st, 32'h20000000 + 32'(i), win_b[i], 1'b0, 1'b1);

    // Load granted, then reset lands before its response can be seen.
    c_ld = mk(1'b1, 1'b0, 12'h010, 32'h0, 3'd2);
    applyStimulus(c_ld, d_ld, 32'hDEADBEEF, 1, 1'b0, 1'b0);
    n_rst = 1'b0;
    #1;
    checkOutput("pulse_c_rvalid", 64'(c_rvalid), 64'h0);
    checkOutput("pulse_c_rdata", 64'(c_rdata), 64'h0);
    checkOutput("pulse_d_rdata", 64'(d_rdata), 64'h0);
    checkOutput("pulse_last_gnt", 64'(dut.last_gnt), 64'h1);
    checkOutput("pulse_grants", 64'({c_gnt, d_gnt, MemWr, MemRead}), 64'h0);
`ifndef DMEM_ARB_RR_EN
    checkOutput("pulse_wait_cnt", 64'(dut.wait_cnt), 64'h0);
`endif
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    applyStimulus(c_ld, d_ld, 32'h0BADF00D, 1, 1'b0, 1'b1);
    applyStimulus(c_ld, d_ld, 32'h5A5A5A5A, win_last, 1'b0, 1'b1);
    applyStimulus(idle_r, idle_r, 32'h0, 0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("cmd_q_drained", 64'(cmd_q.size()), 64'h0);
    checkOutput("rsp_q_drained", 64'(rsp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
